// File: rtl/mem_arbiter_if.sv
// Requester and memory-bus bundle for mem_arbiter.
// slave is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int NUM_PORTS = 2
) ();
    logic                      rdy;
    logic [NUM_PORTS-1:0]      req;
    logic [NUM_PORTS-1:0]      we;
    logic [32*NUM_PORTS-1:0]   addr;
    logic [32*NUM_PORTS-1:0]   wdata;
    logic [2*NUM_PORTS-1:0]    len;
    logic [NUM_PORTS-1:0]      flush;
    logic [NUM_PORTS-1:0]      ok;
    logic [31:0]               rdata;
    logic [NUM_PORTS-1:0]      gnt;
    logic [7:0]                mem_din;
    logic [7:0]                mem_dout;
    logic [31:0]               mem_a;
    logic                      mem_wr;
    logic                      io_buffer_full;

    modport slave (
        input  rdy, req, we, addr, wdata, len, flush,
        input  mem_din, io_buffer_full,
        output ok, rdata, gnt, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, req, we, addr, wdata, len, flush,
        output mem_din, io_buffer_full,
        input  ok, rdata, gnt, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Multi-port arbiter and byte serialiser onto an 8-bit memory bus.
// Little-endian 1-4 byte accesses, IO write pacing, flush and pause.
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_arbiter_if.slave bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_PORTS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_IO_WAIT = 3'd3;
    localparam logic [2:0] S_IO_GAP  = 3'd4;

    logic [2:0]           r_state;
    logic [PW-1:0]        r_g;
    logic [PW-1:0]        r_ptr;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [1:0]           r_len;
    logic [2:0]           r_iss;
    logic [2:0]           r_cap;
    logic                 r_paused;
    logic [31:0]          r_buf;
    logic [31:0]          r_rdata;
    logic [NUM_PORTS-1:0] r_ok;

    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_any;
    logic [PW-1:0]        w_win;
    logic [PW-1:0]        w_idx;
    int                   w_j;
    logic [2:0]           w_n;
    logic [2:0]           w_iss;
    logic [31:0]          w_a;
    logic                 w_io;
    logic                 w_busy;
    logic                 w_wr_slot;
    logic                 w_cap;
    logic [31:0]          w_capd;
    logic [7:0]           w_byte;
    logic                 w_flush_g;
    logic [NUM_PORTS-1:0] w_g_oh;

    assign w_elig    = bus.req & ~bus.flush & ~r_ok;
    assign w_any     = |w_elig;
    assign w_n       = {1'b0, r_len} + 3'd1;
    // After a pause the first uncaptured byte is re-issued.
    assign w_iss     = (r_state == S_READ && r_paused) ? r_cap : r_iss;
    assign w_a       = r_addr + {29'd0, w_iss};
    assign w_io      = (w_a[17:16] == 2'b11);
    assign w_busy    = (r_state != S_IDLE);
    assign w_byte    = r_wdata[{r_iss[1:0], 3'b000} +: 8];
    assign w_flush_g = bus.flush[r_g];
    assign w_g_oh    = NUM_PORTS'(1) << r_g;
    assign w_wr_slot = (r_state == S_WRITE && !(w_io && bus.io_buffer_full))
                     || (r_state == S_IO_WAIT && !bus.io_buffer_full);
    assign w_cap     = (r_state == S_READ) && !r_paused && (r_iss > r_cap);
    assign w_capd    = r_buf
                     | ({24'd0, bus.mem_din} << {r_cap[1:0], 3'b000});

    assign bus.mem_wr   = bus.rdy && w_wr_slot;
    assign bus.mem_a    = w_busy ? w_a : 32'd0;
    assign bus.mem_dout = (w_busy && r_state != S_READ) ? w_byte : 8'd0;
    assign bus.gnt      = w_busy ? w_g_oh : '0;
    assign bus.ok       = r_ok;
    assign bus.rdata    = r_rdata;

    // Pick the winner: lowest index, or first index after the pointer.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        w_j   = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_j   = (ARB_MODE == 0) ? (k - 1)
                                    : ((int'(r_ptr) + k) % NUM_PORTS);
            w_idx = w_j[PW-1:0];
            if (w_elig[w_idx])
                w_win = w_idx;
        end
    end

    // Transfer sequencing; everything freezes while rdy is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_g      <= '0;
            r_ptr    <= PTR_RST;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_len    <= '0;
            r_iss    <= '0;
            r_cap    <= '0;
            r_paused <= 1'b0;
            r_buf    <= '0;
            r_rdata  <= '0;
            r_ok     <= '0;
        end else if (!bus.rdy) begin
            if (r_state == S_READ)
                r_paused <= 1'b1;
        end else begin
            r_ok     <= '0;
            r_paused <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_g     <= w_win;
                        if (ARB_MODE != 0)
                            r_ptr <= w_win;
                        r_addr  <= bus.addr[32*int'(w_win) +: 32];
                        r_wdata <= bus.wdata[32*int'(w_win) +: 32];
                        r_len   <= bus.len[2*int'(w_win) +: 2];
                        r_iss   <= '0;
                        r_cap   <= '0;
                        r_buf   <= '0;
                        r_state <= bus.we[w_win] ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    if (w_flush_g) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_iss < w_n)
                            r_iss <= w_iss + 3'd1;
                        else
                            r_iss <= w_iss;
                        if (w_cap) begin
                            r_cap <= r_cap + 3'd1;
                            r_buf <= w_capd;
                            if (r_cap == w_n - 3'd1) begin
                                r_rdata <= w_capd;
                                r_ok    <= w_g_oh;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                S_WRITE, S_IO_WAIT: begin
                    if (w_wr_slot) begin
                        r_iss <= r_iss + 3'd1;
                        if (w_io) begin
                            r_state <= S_IO_GAP;
                        end else if (r_iss == w_n - 3'd1) begin
                            r_ok    <= w_g_oh;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_state <= S_IO_WAIT;
                    end
                end
                S_IO_GAP: begin
                    if (r_iss == w_n) begin
                        r_ok    <= w_g_oh;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-priority 2-port and
// round-robin 3-port instances sharing clock and reset.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if #(.NUM_PORTS(2)) ia ();
    mem_arbiter_if #(.NUM_PORTS(3)) ib ();

    mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(0)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ia)
    );

    mem_arbiter #(.NUM_PORTS(3), .ARB_MODE(1)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory byte at address a: both nibbles equal a[3:0]+1.
    function automatic logic [7:0] fb(input logic [31:0] a);
        logic [3:0] n;
        n = a[3:0] + 4'd1;
        return {n, n};
    endfunction

    // Memory returns data for the address driven in the previous cycle.
    always @(posedge clk) begin
        ia.mem_din <= fb(ia.mem_a);
        ib.mem_din <= fb(ib.mem_a);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [2:0] rr_gnt [4];
    logic [7:0] rr_dat [4];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ia.rdy = 1'b1; ia.req = '0; ia.we = '0; ia.addr = '0;
        ia.wdata = '0; ia.len = '0; ia.flush = '0; ia.io_buffer_full = 1'b0;
        ib.rdy = 1'b1; ib.req = '0; ib.we = '0; ib.addr = '0;
        ib.wdata = '0; ib.len = '0; ib.flush = '0; ib.io_buffer_full = 1'b0;
        rr_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_dat = '{8'h11, 8'h22, 8'h33, 8'h11};

        // Reset state
        step();
        mid();
        chk("rst_ok",    32'(ia.ok), 32'd0);
        chk("rst_gnt",   32'(ia.gnt), 32'd0);
        chk("rst_wr",    32'(ia.mem_wr), 32'd0);
        chk("rst_a",     ia.mem_a, 32'd0);
        chk("rst_rdata", ia.rdata, 32'd0);
        chk("rst_gnt_b", 32'(ib.gnt), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Port0 word read at 0x100
        step();
        ia.req = 2'b01; ia.we = 2'b00;
        ia.addr[31:0] = 32'h100; ia.len[1:0] = 2'd3;
        mid();
        chk("rd_gnt_t", 32'(ia.gnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            chk("rd_gnt", 32'(ia.gnt), 32'd1);
            chk("rd_a", ia.mem_a, 32'h100 + 32'(i));
        end
        step();
        mid();
        chk("rd_ok_t5", 32'(ia.ok), 32'd0);
        step();
        mid();
        chk("rd_ok_t6", 32'(ia.ok), 32'd1);
        chk("rd_data", ia.rdata, 32'h44332211);
        chk("rd_gnt_ok", 32'(ia.gnt), 32'd0);
        ia.req = 2'b00;
        step();
        mid();
        chk("rd_ok_after", 32'(ia.ok), 32'd0);

        // Simultaneous byte reads: port0 first, port1 at its ok edge
        step();
        ia.req = 2'b11; ia.len = 4'b0000;
        ia.addr[31:0] = 32'h102; ia.addr[63:32] = 32'h105;
        mid();
        step();
        mid();
        chk("pr_gnt0", 32'(ia.gnt), 32'd1);
        step();
        step();
        mid();
        chk("pr_ok0", 32'(ia.ok), 32'd1);
        chk("pr_data0", ia.rdata, 32'h33);
        ia.req = 2'b10;
        step();
        mid();
        chk("pr_gnt1", 32'(ia.gnt), 32'd2);
        chk("pr_a1", ia.mem_a, 32'h105);
        step();
        step();
        mid();
        chk("pr_ok1", 32'(ia.ok), 32'd2);
        chk("pr_data1", ia.rdata, 32'h66);
        ia.req = 2'b00;

        // Port1 half write 0xBEEF to 0x1FFFF
        step();
        ia.req = 2'b10; ia.we = 2'b10;
        ia.addr[63:32] = 32'h1FFFF; ia.wdata[63:32] = 32'hBEEF;
        ia.len[3:2] = 2'd1;
        mid();
        step();
        mid();
        chk("hw_wr0", 32'(ia.mem_wr), 32'd1);
        chk("hw_a0", ia.mem_a, 32'h1FFFF);
        chk("hw_d0", 32'(ia.mem_dout), 32'hEF);
        step();
        mid();
        chk("hw_wr1", 32'(ia.mem_wr), 32'd1);
        chk("hw_a1", ia.mem_a, 32'h20000);
        chk("hw_d1", 32'(ia.mem_dout), 32'hBE);
        step();
        mid();
        chk("hw_ok", 32'(ia.ok), 32'd2);
        chk("hw_wr_end", 32'(ia.mem_wr), 32'd0);
        ia.req = 2'b00; ia.we = 2'b00;

        // Half read across the top of the address space
        step();
        ia.req = 2'b01; ia.addr[31:0] = 32'hFFFF_FFFF; ia.len[1:0] = 2'd1;
        mid();
        step();
        mid();
        chk("wrap_a0", ia.mem_a, 32'hFFFF_FFFF);
        step();
        mid();
        chk("wrap_a1", ia.mem_a, 32'h0);
        step();
        step();
        mid();
        chk("wrap_ok", 32'(ia.ok), 32'd1);
        chk("wrap_data", ia.rdata, 32'h1100);
        ia.req = 2'b00;

        // IO byte write with buffer full for three cycles
        step();
        ia.req = 2'b01; ia.we = 2'b01; ia.addr[31:0] = 32'h30000;
        ia.wdata[31:0] = 32'h41; ia.len[1:0] = 2'd0;
        ia.io_buffer_full = 1'b1;
        mid();
        for (int i = 0; i < 3; i++) begin
            step();
            mid();
            chk("io_hold", 32'(ia.mem_wr), 32'd0);
            chk("io_gnt", 32'(ia.gnt), 32'd1);
        end
        step();
        ia.io_buffer_full = 1'b0;
        mid();
        chk("io_wr", 32'(ia.mem_wr), 32'd1);
        chk("io_a", ia.mem_a, 32'h30000);
        chk("io_d", 32'(ia.mem_dout), 32'h41);
        step();
        mid();
        chk("io_gap_wr", 32'(ia.mem_wr), 32'd0);
        chk("io_gap_ok", 32'(ia.ok), 32'd0);
        step();
        mid();
        chk("io_ok", 32'(ia.ok), 32'd1);
        ia.req = 2'b00; ia.we = 2'b00;

        // Word read at 0x104 paused for two cycles after byte 1
        step();
        ia.req = 2'b01; ia.addr[31:0] = 32'h104; ia.len[1:0] = 2'd3;
        mid();
        step();
        step();
        step();
        mid();
        chk("ps_a2", ia.mem_a, 32'h106);
        step();
        ia.rdy = 1'b0;
        mid();
        chk("ps_wr", 32'(ia.mem_wr), 32'd0);
        chk("ps_gnt", 32'(ia.gnt), 32'd1);
        step();
        step();
        ia.rdy = 1'b1;
        mid();
        chk("ps_reissue", ia.mem_a, 32'h106);
        step();
        mid();
        chk("ps_a3", ia.mem_a, 32'h107);
        step();
        mid();
        chk("ps_ok_early", 32'(ia.ok), 32'd0);
        step();
        mid();
        chk("ps_ok", 32'(ia.ok), 32'd1);
        chk("ps_data", ia.rdata, 32'h88776655);
        ia.req = 2'b00;
        step();
        mid();
        chk("ps_no_dup", 32'(ia.ok), 32'd0);

        // Flush of port0 during a read
        step();
        ia.req = 2'b01; ia.addr[31:0] = 32'h100; ia.len[1:0] = 2'd3;
        mid();
        step();
        step();
        ia.flush = 2'b01;
        mid();
        chk("fl_gnt", 32'(ia.gnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            chk("fl_idle", 32'(ia.gnt), 32'd0);
            chk("fl_no_ok", 32'(ia.ok), 32'd0);
        end
        ia.req = 2'b00; ia.flush = 2'b00;

        // Flush during a write does not abort it
        step();
        ia.req = 2'b10; ia.we = 2'b10; ia.addr[63:32] = 32'h200;
        ia.wdata[63:32] = 32'hDDCCBBAA; ia.len[3:2] = 2'd3;
        mid();
        step();
        ia.flush = 2'b10;
        mid();
        chk("fw_d0", 32'(ia.mem_dout), 32'hAA);
        step();
        step();
        step();
        mid();
        chk("fw_wr3", 32'(ia.mem_wr), 32'd1);
        chk("fw_a3", ia.mem_a, 32'h203);
        chk("fw_d3", 32'(ia.mem_dout), 32'hDD);
        step();
        mid();
        chk("fw_ok", 32'(ia.ok), 32'd2);
        ia.req = 2'b00; ia.we = 2'b00; ia.flush = 2'b00;

        // Reset in the middle of a write
        step();
        ia.req = 2'b01; ia.we = 2'b01; ia.addr[31:0] = 32'h300;
        ia.wdata[31:0] = 32'h11223344; ia.len[1:0] = 2'd3;
        mid();
        step();
        mid();
        chk("rw_wr", 32'(ia.mem_wr), 32'd1);
        step();
        mid();
        rst = 1'b1;
        #1;
        chk("rw_async_wr", 32'(ia.mem_wr), 32'd0);
        chk("rw_async_gnt", 32'(ia.gnt), 32'd0);
        chk("rw_async_a", ia.mem_a, 32'd0);
        ia.req = 2'b00; ia.we = 2'b00;
        step();
        rst = 1'b0;
        step();
        mid();
        chk("rw_after", 32'(ia.gnt), 32'd0);

        // Round-robin, three ports requesting continuously
        step();
        ib.req = 3'b111; ib.len = 6'd0;
        ib.addr[31:0] = 32'h100; ib.addr[63:32] = 32'h101;
        ib.addr[95:64] = 32'h102;
        mid();
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            chk("rr_gnt", 32'(ib.gnt), 32'(rr_gnt[i]));
            step();
            step();
            mid();
            chk("rr_ok", 32'(ib.ok), 32'(rr_gnt[i]));
            chk("rr_data", ib.rdata, 32'(rr_dat[i]));
        end
        ib.req = 3'b000;
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised memory-bus arbiter and byte-serialiser between the core's NUM_PORTS requesters (instruction fetch, load/store unit, future prefetch/DMA) and the single 8-bit external memory bus. It supersedes the fixed two-client memory controller by adding:

- a configurable port count;
- fixed-priority or round-robin arbitration;
- per-port read flush;
- restart-safe handling of rdy_in pauses.

Access sizes are 1–4 bytes, little-endian.

## Interface
- NUM_PORTS, 2: number of requester ports (1–8); port 0 is highest priority in fixed mode.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global ready; low pauses the block.
- req  in  NUM_PORTS  per-port request; held with its fields until ok or flush.
- we  in  NUM_PORTS  1 = write, 0 = read.
- addr  in  32*NUM_PORTS  byte address, port p at [32p+31:32p].
- wdata  in  32*NUM_PORTS  write data, byte i at [8i+7:8i] of the port slice.
- len  in  2*NUM_PORTS  access size minus one (0 = byte, 1 = half, 2 = 3 bytes, 3 = word).
- flush  in  NUM_PORTS  abort the port's pending or in-progress read.
- ok  out  NUM_PORTS  one-cycle completion pulse, registered.
- rdata  out  32  read data, zero-extended; valid only while an ok bit is high.
- gnt  out  NUM_PORTS  one-hot, current owner of the bus; 0 when idle.
- mem_din  in  8  memory read byte; returns data for the address driven in the previous cycle.
- mem_dout  out  8  memory write byte.
- mem_a  out  32  memory byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  UART TX buffer full.

## Operation
- States: IDLE, READ, WRITE, IO_WAIT, IO_GAP.
- Reset values: all outputs 0, state IDLE, round-robin pointer NUM_PORTS-1 (so port 0 wins first).
- IDLE arbitration:
  - Eligible ports: req set, flush clear, and ok not high this cycle.
  - Fixed mode: lowest eligible index wins.
  - Round-robin mode: first eligible index after the pointer, with wrap-around. The pointer updates to the winner on grant.
  - Grant g latches addr, we, len and wdata; n = len+1; issue and capture indices are reset to 0.
- READ:
  - Byte i address is addr+i, with 32-bit wrap.
  - Issue index advances each cycle until n bytes have been issued.
  - Capture index fills rdata byte i from mem_din one cycle after byte i was issued. Unused upper bytes are 0.
  - After capturing byte n-1: pulse ok[g], return to IDLE.
- WRITE:
  - Byte i is driven with mem_wr=1 for one cycle.
  - After byte n-1: ok[g] pulses in the next cycle, return to IDLE.
- IO target (addr[17:16]==2'b11):
  - Before each IO write byte, if io_buffer_full=1, enter IO_WAIT with mem_wr=0 until it is 0.
  - After each IO write byte, IO_GAP inserts one cycle with mem_wr=0. This covers the one-cycle lag in io_buffer_full.
  - IO reads follow normal READ timing.
- flush:
  - flush[g] during READ aborts the read: no ok, mem_wr=0, IDLE on the next edge.
  - flush on a non-granted port only masks it from arbitration.
  - flush never aborts a WRITE; the write completes and ok pulses.
- rdy low:
  - State, indices, latched fields, pointer and ok/rdata hold.
  - mem_wr is forced 0, and no capture occurs.
  - On resume, the issue index rewinds to the capture index, and the first uncaptured byte is re-issued.
  - A write byte whose cycle was paused is re-driven.
- Asynchronous reset mid-transfer drops the transfer immediately; all outputs go to their reset values.

## Timing
- Cycle numbering: a request is visible in cycle t and is granted at the edge ending t; gnt is high from cycle t+1.
- Read: address byte i is driven in cycle t+1+i; mem_din carries byte i in cycle t+2+i; ok and rdata are valid in cycle t+n+2.
- Word read: ok 6 cycles after the request appears.
- Write (non-IO, io_buffer_full=0): mem_wr=1 in cycles t+1..t+n; ok in cycle t+n+1.
- Back-to-back: a new request is visible at the earliest in the ok cycle, but the just-served port is masked that cycle. The next grant can occur at the edge ending the ok cycle.
- ok is never high for two ports at once. gnt clears in the ok cycle.

## Test plan
- Fixed mode, NUM_PORTS=2: port0 word read at 0x100, with memory returning 0x11,0x22,0x33,0x44 → mem_a = 0x100..0x103 in consecutive cycles; ok[0] in cycle t+6; rdata = 0x44332211.
- Fixed mode: port0 and port1 request in the same cycle → port0 is served first; port1 is granted at the edge ending port0's ok cycle. Round-robin with NUM_PORTS=3 and all ports requesting continuously → grants 0,1,2,0.
- Port1 half write 0xBEEF to 0x1FFFF → mem_wr=1 with (0x1FFFF,0xEF), then (0x20000,0xBE); ok[1] one cycle later. Address 0xFFFFFFFF+1 wraps to 0.
- IO byte write 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then one write cycle, then one IO_GAP cycle, then ok.
- Word read with rdy low for 2 cycles after byte 1 has been captured → byte 2 is re-issued on resume; final rdata is correct; no duplicate ok.
- flush[0] mid-read → no ok[0], next edge IDLE. flush during a write → write completes with ok. rst asserted mid-write → mem_wr=0 asynchronously.
